// File: rtl/rmt_recovery_seq.sv
// rmt_recovery_seq: owns the rename map table (RMT) write ports.
// In normal operation, rename-stage map writes pass straight through to the RMT.
// On recover_i, rename is stalled and the architectural map table (AMT) is copied
// into the RMT, WR_PORTS entries per cycle, through a one-stage read pipe.
//
// Interface timing: amt_rd_en_o is a strobe with no back-pressure. The AMT always
// returns amt_data_i on the cycle after the strobe. rmt_we_o is a fire-and-forget
// write valid. While stall_o is high, rename must hold, and ren_we_i is ignored.
module rmt_recovery_seq #(
    parameter int SIZE_RMT  = 32,
    parameter int RMT_INDEX = 5,
    parameter int PHY_WIDTH = 6,
    parameter int WR_PORTS  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           recover_i,
    input  logic [WR_PORTS-1:0]            ren_we_i,
    input  logic [WR_PORTS*RMT_INDEX-1:0]  ren_addr_i,
    input  logic [WR_PORTS*PHY_WIDTH-1:0]  ren_data_i,
    output logic                           amt_rd_en_o,
    output logic [WR_PORTS*RMT_INDEX-1:0]  amt_rd_addr_o,
    input  logic [WR_PORTS*PHY_WIDTH-1:0]  amt_data_i,
    output logic [WR_PORTS-1:0]            rmt_we_o,
    output logic [WR_PORTS*RMT_INDEX-1:0]  rmt_addr_o,
    output logic [WR_PORTS*PHY_WIDTH-1:0]  rmt_data_o,
    output logic                           stall_o,
    output logic                           done_o,
    output logic [1:0]                     dbg_state_o
);

    localparam int NUM_BATCH = SIZE_RMT / WR_PORTS;
    localparam int CNT_W     = $clog2(NUM_BATCH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BATCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_vld_q, wr_vld_d;
    logic [RMT_INDEX-1:0] wr_base_q, wr_base_d;
    logic [RMT_INDEX-1:0] rd_base;

    // State, batch counter and write-pipe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_base_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_vld_q  <= wr_vld_d;
            wr_base_q <= wr_base_d;
        end
    end

    // Next-state logic and AMT read generation.
    // A restart in READ still issues this cycle's read. That batch retires
    // harmlessly through the write pipe, because it is AMT data.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        amt_rd_en_o   = 1'b0;
        amt_rd_addr_o = '0;
        rd_base       = RMT_INDEX'(int'(cnt_q) * WR_PORTS);
        wr_vld_d      = 1'b0;
        wr_base_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (recover_i) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                amt_rd_en_o = 1'b1;
                wr_vld_d    = 1'b1;
                wr_base_d   = rd_base;
                for (int p = 0; p < WR_PORTS; p++) begin
                    amt_rd_addr_o[p*RMT_INDEX +: RMT_INDEX] = rd_base + RMT_INDEX'(p);
                end
                if (recover_i) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LAST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LAST: begin
                if (recover_i) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // RMT write mux. Recovery writes from the pipe take priority.
    // Rename writes pass through only when idle, so recover_i never reaches rmt_*_o combinationally.
    always_comb begin
        rmt_we_o   = '0;
        rmt_addr_o = '0;
        rmt_data_o = '0;
        if (wr_vld_q) begin
            rmt_we_o   = '1;
            rmt_data_o = amt_data_i;
            for (int p = 0; p < WR_PORTS; p++) begin
                rmt_addr_o[p*RMT_INDEX +: RMT_INDEX] = wr_base_q + RMT_INDEX'(p);
            end
        end else if (state_q == ST_IDLE) begin
            rmt_we_o   = ren_we_i;
            rmt_addr_o = ren_addr_i;
            rmt_data_o = ren_data_i;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        stall_o     = (state_q != ST_IDLE);
        done_o      = (state_q == ST_LAST);
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_rmt_recovery_seq.sv
// Directed testbench for rmt_recovery_seq. It covers reset, pass-through,
// a full recovery pass, restart, mid-pass reset and back-to-back passes.
module tb_rmt_recovery_seq;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        recover_i;
    logic [7:0]  ren_we_i;
    logic [39:0] ren_addr_i;
    logic [47:0] ren_data_i;
    logic        amt_rd_en_o;
    logic [39:0] amt_rd_addr_o;
    logic [47:0] amt_data_i;
    logic [7:0]  rmt_we_o;
    logic [39:0] rmt_addr_o;
    logic [47:0] rmt_data_o;
    logic        stall_o;
    logic        done_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    rmt_recovery_seq dut (
        .clk          (clk),
        .reset        (reset),
        .recover_i    (recover_i),
        .ren_we_i     (ren_we_i),
        .ren_addr_i   (ren_addr_i),
        .ren_data_i   (ren_data_i),
        .amt_rd_en_o  (amt_rd_en_o),
        .amt_rd_addr_o(amt_rd_addr_o),
        .amt_data_i   (amt_data_i),
        .rmt_we_o     (rmt_we_o),
        .rmt_addr_o   (rmt_addr_o),
        .rmt_data_o   (rmt_data_o),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    // AMT model: the tag for index i is i+32, returned one cycle after the strobe.
    always @(posedge clk) begin
        if (amt_rd_en_o) begin
            for (int p = 0; p < 8; p++) begin
                amt_data_i[p*6 +: 6] <= {1'b1, amt_rd_addr_o[p*5 +: 5]};
            end
        end else begin
            amt_data_i <= '0;
        end
    end

    function automatic logic [39:0] batch_addr(input int b);
        logic [39:0] r;
        for (int p = 0; p < 8; p++) r[p*5 +: 5] = 5'(b * 8 + p);
        return r;
    endfunction

    function automatic logic [47:0] batch_data(input int b);
        logic [47:0] r;
        for (int p = 0; p < 8; p++) r[p*6 +: 6] = 6'(b * 8 + p + 32);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output for one cycle.
    // rd_b / wr_b give the batch being read or written, and -1 means none.
    task automatic chk_cycle(input string tag, input int rd_b, input int wr_b,
                             input logic stall, input logic done, input logic [1:0] st);
        chk($sformatf("%s.stall", tag), 64'(stall_o), 64'(stall));
        chk($sformatf("%s.done", tag), 64'(done_o), 64'(done));
        chk($sformatf("%s.state", tag), 64'(dbg_state_o), 64'(st));
        chk($sformatf("%s.amt_en", tag), 64'(amt_rd_en_o), 64'(rd_b >= 0));
        chk($sformatf("%s.amt_addr", tag), 64'(amt_rd_addr_o),
            (rd_b >= 0) ? 64'(batch_addr(rd_b)) : 64'd0);
        if (wr_b >= 0) begin
            chk($sformatf("%s.rmt_we", tag), 64'(rmt_we_o), 64'hFF);
            chk($sformatf("%s.rmt_addr", tag), 64'(rmt_addr_o), 64'(batch_addr(wr_b)));
            chk($sformatf("%s.rmt_data", tag), 64'(rmt_data_o), 64'(batch_data(wr_b)));
        end else if (!stall) begin
            chk($sformatf("%s.pass_we", tag), 64'(rmt_we_o), 64'(ren_we_i));
            chk($sformatf("%s.pass_addr", tag), 64'(rmt_addr_o), 64'(ren_addr_i));
            chk($sformatf("%s.pass_data", tag), 64'(rmt_data_o), 64'(ren_data_i));
        end else begin
            chk($sformatf("%s.mask_we", tag), 64'(rmt_we_o), 64'd0);
            chk($sformatf("%s.mask_addr", tag), 64'(rmt_addr_o), 64'd0);
            chk($sformatf("%s.mask_data", tag), 64'(rmt_data_o), 64'd0);
        end
    endtask

    // Advance to the next cycle, apply recover/reset, and settle before the checks.
    task automatic cyc(input logic rec, input logic rst);
        @(posedge clk);
        #1;
        recover_i = rec;
        reset     = rst;
        #3;
    endtask

    task automatic set_ren(input logic [7:0] we, input logic [39:0] addr, input logic [47:0] data);
        ren_we_i   = we;
        ren_addr_i = addr;
        ren_data_i = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        recover_i = 1'b0;
        set_ren(8'h01, 40'd5, 48'd9);

        // 1: reset, then pass-through
        repeat (3) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk_cycle("t1", -1, -1, 1'b0, 1'b0, S_IDLE);
        chk("t1.we_const", 64'(rmt_we_o), 64'h01);
        chk("t1.addr0", 64'(rmt_addr_o[4:0]), 64'd5);
        chk("t1.data0", 64'(rmt_data_o[5:0]), 64'd9);

        // 2+3: full pass, rename held writing the whole time
        set_ren(8'hFF, 40'hFF_FFFF_FFFF, 48'hAAAA_AAAA_AAAA);
        cyc(1'b1, 1'b0);
        chk_cycle("t2.T", -1, -1, 1'b0, 1'b0, S_IDLE);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0);
            chk_cycle($sformatf("t2.T+%0d", k), k - 1, k - 2, 1'b1, 1'b0, S_READ);
            chk($sformatf("t2.port0_T+%0d", k), 64'(amt_rd_addr_o[4:0]), 64'((k - 1) * 8));
        end
        cyc(1'b0, 1'b0);
        chk_cycle("t2.T+5", -1, 3, 1'b1, 1'b1, S_LAST);
        cyc(1'b0, 1'b0);
        chk_cycle("t2.T+6", -1, -1, 1'b0, 1'b0, S_IDLE);

        // 4: restart in READ at T+2
        cyc(1'b1, 1'b0);
        chk_cycle("t4.T", -1, -1, 1'b0, 1'b0, S_IDLE);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+1", 0, -1, 1'b1, 1'b0, S_READ);
        cyc(1'b1, 1'b0);
        chk_cycle("t4.T+2", 1, 0, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+3", 0, 1, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+4", 1, 0, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+5", 2, 1, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+6", 3, 2, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+7", -1, 3, 1'b1, 1'b1, S_LAST);
        cyc(1'b0, 1'b0);
        chk_cycle("t4.T+8", -1, -1, 1'b0, 1'b0, S_IDLE);

        // 5: reset asserted during T+3 aborts the pass
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk_cycle("t5.T+1", 0, -1, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b0);
        chk_cycle("t5.T+2", 1, 0, 1'b1, 1'b0, S_READ);
        cyc(1'b0, 1'b1);
        chk_cycle("t5.T+3", 2, 1, 1'b1, 1'b0, S_READ);
        set_ren(8'h00, 40'd0, 48'd0);
        cyc(1'b0, 1'b0);
        chk_cycle("t5.T+4", -1, -1, 1'b0, 1'b0, S_IDLE);
        chk("t5.zero_we", 64'(rmt_we_o), 64'd0);
        set_ren(8'h81, 40'h3A_0000_0011, 48'h2C_0000_0015);
        cyc(1'b0, 1'b0);
        chk_cycle("t5.T+5", -1, -1, 1'b0, 1'b0, S_IDLE);
        chk("t5.pass_we_const", 64'(rmt_we_o), 64'h81);
        chk("t5.pass_addr_const", 64'(rmt_addr_o), 64'h3A_0000_0011);
        cyc(1'b0, 1'b0);
        chk_cycle("t5.T+6", -1, -1, 1'b0, 1'b0, S_IDLE);

        // 6: recover_i in the LAST cycle chains a second pass
        set_ren(8'hFF, 40'h12_3456_789A, 48'h5555_5555_5555);
        cyc(1'b1, 1'b0);
        chk_cycle("t6.T", -1, -1, 1'b0, 1'b0, S_IDLE);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0);
            chk_cycle($sformatf("t6.T+%0d", k), k - 1, k - 2, 1'b1, 1'b0, S_READ);
        end
        cyc(1'b1, 1'b0);
        chk_cycle("t6.T+5", -1, 3, 1'b1, 1'b1, S_LAST);
        for (int k = 6; k <= 9; k++) begin
            cyc(1'b0, 1'b0);
            chk_cycle($sformatf("t6.T+%0d", k), k - 6, k - 7, 1'b1, 1'b0, S_READ);
        end
        cyc(1'b0, 1'b0);
        chk_cycle("t6.T+10", -1, 3, 1'b1, 1'b1, S_LAST);
        cyc(1'b0, 1'b0);
        chk_cycle("t6.T+11", -1, -1, 1'b0, 1'b0, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
